voting_tally_ctrl: RTL and testbench

- Sequential front end for the plurality-voting function.
- Collects NUM_VOTERS ballots serially over a valid/ready handshake and keeps one tally counter per candidate code.
- Once all ballots are in, it selects the winning candidate and tie status, then holds the result until the consumer accepts it.
- Sits between the ballot source and the downstream result consumer, replacing the fully parallel ballot input with a timed collection session.

---
 rtl/voting_tally_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_voting_tally_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voting_tally_ctrl.sv
// voting_tally_ctrl: serial ballot collection with per-candidate tallies and a plurality decision.
// Optional collection timeout (parameter TIMEOUT_CYC, port timed_out) is enabled by VOTING_TALLY_TIMEOUT_EN.
module voting_tally_ctrl #(
    parameter int NUM_VOTERS = 4,
    parameter int CAND_W     = 2,
    parameter int CNT_W      = 8
`ifdef VOTING_TALLY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ballot_valid,
    output logic              ballot_ready,
    input  logic [CAND_W-1:0] ballot,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CAND_W-1:0] winner,
    output logic              tie,
    output logic [CNT_W-1:0]  win_count,
`ifdef VOTING_TALLY_TIMEOUT_EN
    output logic              timed_out,
`endif
    output logic              busy
);
    localparam int NC = 1 << CAND_W;

    typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, REPORT} state_t;

    typedef struct packed {
        logic [CAND_W-1:0] idx;
        logic [CNT_W-1:0]  cnt;
        logic              tie;
    } best_t;

    state_t            state, state_next;
    logic [1:0]        rst_sync;
    logic              rst_int_n;
    logic [CNT_W-1:0]  tally [NC];
    logic [CNT_W-1:0]  ballot_cnt;
    logic [CAND_W-1:0] scan_idx;
    logic              accept;
    logic              last_ballot;
    logic              to_hit;
    logic [CAND_W-1:0] idx_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic              vld_p0;
    logic              last_p0;
    best_t             best;
    best_t             best_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Strictly greater takes over the lead, so equal counts stay with the lowest index.
    function automatic best_t scan_step(input best_t b, input logic [CAND_W-1:0] i,
                                        input logic [CNT_W-1:0] c);
        best_t r;
        r = b;
        if (c > b.cnt) begin
            r.idx = i;
            r.cnt = c;
            r.tie = 1'b0;
        end else if ((c == b.cnt) && (i != b.idx)) begin
            r.tie = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign accept      = ballot_valid && (state == COLLECT);
    assign last_ballot = accept && (ballot_cnt == CNT_W'(NUM_VOTERS - 1));
    assign best_nxt    = scan_step(best, idx_p0, cnt_p0);

`ifdef VOTING_TALLY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;

    assign to_hit = (state == COLLECT) && !accept && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idle_cnt  <= '0;
            timed_out <= 1'b0;
        end else if ((state == IDLE) && start) begin
            idle_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == COLLECT) begin
            idle_cnt <= accept ? '0 : idle_cnt + TO_W'(1);
            if (to_hit) timed_out <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        ballot_ready = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = COLLECT;
            end
            COLLECT: begin
                ballot_ready = 1'b1;
                if (last_ballot || to_hit) state_next = DECIDE;
            end
            DECIDE:  if (&scan_idx) state_next = REPORT;
            REPORT:  if (result_valid && result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < NC; i++) tally[i] <= '0;
            ballot_cnt <= '0;
            scan_idx   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < NC; i++) tally[i] <= '0;
                    ballot_cnt <= '0;
                    scan_idx   <= '0;
                end
                COLLECT: if (accept) begin
                    tally[ballot] <= sat_inc(tally[ballot]);
                    ballot_cnt    <= ballot_cnt + CNT_W'(1);
                end
                DECIDE:  scan_idx <= scan_idx + CAND_W'(1);
                default: ;
            endcase
        end
    end

    // Stage p0: fetch the tally of the candidate being scanned
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idx_p0  <= '0;
            cnt_p0  <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            idx_p0  <= scan_idx;
            cnt_p0  <= tally[scan_idx];
            vld_p0  <= (state == DECIDE);
            last_p0 <= (state == DECIDE) && (&scan_idx);
        end
    end

    // Stage p1: fold into the running best; the last candidate publishes the result
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            best         <= '0;
            winner       <= '0;
            tie          <= 1'b0;
            win_count    <= '0;
            result_valid <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                best <= '0;
            end else if (vld_p0) begin
                best <= best_nxt;
            end
            if (vld_p0 && last_p0) begin
                winner       <= best_nxt.idx;
                tie          <= best_nxt.tie;
                win_count    <= best_nxt.cnt;
                result_valid <= 1'b1;
            end else if ((state == REPORT) && result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// Randomized self-checking bench for voting_tally_ctrl against a session-level reference model.
// Define VOTING_TALLY_TIMEOUT_EN to also exercise the collection timeout.
module tb_voting_tally_ctrl;
    localparam int NV = 4;
    localparam int CW = 2;
    localparam int NC = 1 << CW;
    localparam int KW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ballot_valid;
    logic          ballot_ready;
    logic [CW-1:0] ballot;
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] winner;
    logic          tie;
    logic [KW-1:0] win_count;
    logic          busy;
`ifdef VOTING_TALLY_TIMEOUT_EN
    logic          timed_out;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    // reference model state (session level)
    bit m_busy = 0, m_full = 0, m_to = 0;
    int m_nacc = 0, m_last = 0, m_idle = 0;
    int m_tally [NC];
    int m_win = 0, m_tie = 0, m_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    voting_tally_ctrl #(
        .NUM_VOTERS(NV),
        .CAND_W(CW),
        .CNT_W(KW)
`ifdef VOTING_TALLY_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ballot_valid(ballot_valid),
        .ballot_ready(ballot_ready),
        .ballot(ballot),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .winner(winner),
        .tie(tie),
        .win_count(win_count),
`ifdef VOTING_TALLY_TIMEOUT_EN
        .timed_out(timed_out),
`endif
        .busy(busy)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Plurality from plain counts: the maximum, the lowest index holding it, and how many share it.
    function automatic void model_close();
        int mx;
        int nmax;
        mx = -1;
        nmax = 0;
        for (int i = 0; i < NC; i++) if (m_tally[i] > mx) mx = m_tally[i];
        for (int i = NC - 1; i >= 0; i--) begin
            if (m_tally[i] == mx) begin
                m_win = i;
                nmax++;
            end
        end
        m_cnt  = mx;
        m_tie  = (nmax > 1) ? 1 : 0;
        m_full = 1;
        m_last = cyc + 1;
    endfunction

    always @(negedge clk) begin
        bit exp_ready;
        bit exp_rv;
        if (!rst_n) begin
            m_busy = 0; m_full = 0; m_to = 0; m_nacc = 0; m_idle = 0;
            m_win = 0; m_tie = 0; m_cnt = 0;
        end
        exp_ready = m_busy && !m_full;
        exp_rv    = m_busy && m_full && ((cyc - m_last) >= 5);
        check("busy", 64'(busy), 64'(m_busy));
        check("ballot_ready", 64'(ballot_ready), 64'(exp_ready));
        check("result_valid", 64'(result_valid), 64'(exp_rv));
        if (exp_rv || !m_busy) begin
            check("winner", 64'(winner), 64'(m_win));
            check("tie", 64'(tie), 64'(m_tie));
            check("win_count", 64'(win_count), 64'(m_cnt));
`ifdef VOTING_TALLY_TIMEOUT_EN
            check("timed_out", 64'(timed_out), 64'(m_to));
`endif
        end
        if (rst_n) begin
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_full = 0; m_to = 0; m_nacc = 0; m_idle = 0;
                    for (int i = 0; i < NC; i++) m_tally[i] = 0;
                end
            end else if (exp_ready) begin
                if (ballot_valid) begin
                    m_tally[ballot]++;
                    m_nacc++;
                    m_idle = 0;
                    if (m_nacc == NV) model_close();
                end else begin
`ifdef VOTING_TALLY_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == TO) begin
                        m_to = 1;
                        model_close();
                    end
`endif
                end
            end else if (exp_rv && result_ready) begin
                m_busy = 0;
            end
        end
    end

    task automatic start_session();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [CW-1:0] b, input int gap);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        ballot_valid = 1'b1;
        ballot = b;
        do begin
            @(negedge clk);
            acc = ballot_ready;
            if (acc) last_acc_cyc = cyc + 1;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 200);
        check("ballot_accepted", 64'(acc), 64'd1);
        ballot_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic finish_session(input int stall, input bit with_start, input bit lit,
                                  input int e_win, input int e_tie, input int e_cnt,
                                  input int e_lat, input int e_to);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!result_valid && guard < 200);
        check("result_valid_seen", 64'(result_valid), 64'd1);
        if (lit && e_lat >= 0) check("latency", 64'(cyc - last_acc_cyc), 64'(e_lat));
        repeat (stall) @(negedge clk);
        if (lit) begin
            check("winner_lit", 64'(winner), 64'(e_win));
            check("tie_lit", 64'(tie), 64'(e_tie));
            check("win_count_lit", 64'(win_count), 64'(e_cnt));
`ifdef VOTING_TALLY_TIMEOUT_EN
            check("timed_out_lit", 64'(timed_out), 64'(e_to));
`endif
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        start = with_start;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_ack", 64'(busy), 64'd0);
        check("rv_after_ack", 64'(result_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ballot_valid = 1'b0;
        ballot = '0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ballot_ready), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);
        check("rst_win_count", 64'(win_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        start_session();
        send(2'd1, 0); send(2'd1, 0); send(2'd2, 0); send(2'd3, 0);
        finish_session(0, 0, 1, 1, 0, 2, 5, 0);

        start_session();
        send(2'd3, 0); send(2'd3, 0); send(2'd0, 0); send(2'd0, 0);
        finish_session(0, 0, 1, 0, 1, 2, 5, 0);

        start_session();
        for (int i = 0; i < NV; i++) send(2'd2, 1);
        ballot_valid = 1'b1;
        ballot = 2'd1;
        repeat (3) begin @(posedge clk); #1; end
        ballot_valid = 1'b0;
        finish_session(10, 0, 1, 2, 0, 4, 5, 0);

        start_session();
        send(2'd0, 0); send(2'd1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("busy_in_reset", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        start_session();
        send(2'd0, 0); send(2'd1, 0); send(2'd2, 0); send(2'd3, 0);
        finish_session(0, 0, 1, 0, 1, 1, 5, 0);

        start_session();
        send(2'd1, 0);
        start_session();
        send(2'd0, 0); send(2'd0, 0); send(2'd3, 0);
        finish_session(2, 1, 1, 0, 0, 2, 5, 0);
        repeat (3) @(negedge clk);
        check("start_in_report_ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;

        for (int s = 0; s < 20; s++) begin
            start_session();
            for (int v = 0; v < NV; v++) send(CW'($urandom_range(0, NC - 1)), $urandom_range(0, 2));
            finish_session($urandom_range(0, 3), 0, 0, 0, 0, 0, -1, 0);
        end

`ifdef VOTING_TALLY_TIMEOUT_EN
        start_session();
        send(2'd3, 0); send(2'd3, 0);
        finish_session(0, 0, 1, 3, 0, 2, -1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation reached time limit at cycle %0d, expected completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
